// File: rtl/mem_burst_arbiter.sv
// Round-robin burst arbiter sharing one memory-controller burst port between a
// write master and a read master, with a one-cycle turnaround between bursts.
module mem_burst_arbiter #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 28,
    parameter int BUSRT_BITS    = 10
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    input  logic                     wr_burst_req,
    input  logic [BUSRT_BITS-1:0]    wr_burst_len,
    input  logic [ADDR_BITS-1:0]     wr_burst_addr,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     wr_burst_data_req,
    output logic                     wr_burst_finish,
    input  logic                     rd_burst_req,
    input  logic [BUSRT_BITS-1:0]    rd_burst_len,
    input  logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish,
    output logic                     mem_wr_burst_req,
    output logic                     mem_rd_burst_req,
    output logic [BUSRT_BITS-1:0]    mem_burst_len,
    output logic [ADDR_BITS-1:0]     mem_burst_addr,
    input  logic                     mem_wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0] mem_wr_burst_data,
    input  logic                     mem_rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_rd_burst_data,
    input  logic                     mem_wr_burst_finish,
    input  logic                     mem_rd_burst_finish,
    output logic [1:0]               arb_owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_last_rd, w_last_rd_nxt;
    logic                  r_mem_wr_req, w_mem_wr_req_nxt;
    logic                  r_mem_rd_req, w_mem_rd_req_nxt;
    logic [BUSRT_BITS-1:0] r_len, w_len_nxt;
    logic [ADDR_BITS-1:0]  r_addr, w_addr_nxt;
    logic [1:0]            r_owner, w_owner_nxt;
    logic                  w_pick_wr;
    logic                  w_wr_grant;
    logic                  w_rd_grant;

    // Write wins unless the read master is also asking and write had the last turn.
    assign w_pick_wr = wr_burst_req && (!rd_burst_req || r_last_rd);

    // NOTE: gating with rst_n drops a grant in the same cycle reset is asserted,
    // not one edge later, so a late controller finish never reaches a master.
    assign w_wr_grant = (r_state == S_WR) && rst_n;
    assign w_rd_grant = (r_state == S_RD) && rst_n;

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_rd    <= 1'b1;
            r_mem_wr_req <= 1'b0;
            r_mem_rd_req <= 1'b0;
            r_len        <= '0;
            r_addr       <= '0;
            r_owner      <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_last_rd    <= w_last_rd_nxt;
            r_mem_wr_req <= w_mem_wr_req_nxt;
            r_mem_rd_req <= w_mem_rd_req_nxt;
            r_len        <= w_len_nxt;
            r_addr       <= w_addr_nxt;
            r_owner      <= w_owner_nxt;
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no
        // path through the case leaves a signal unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_last_rd_nxt    = r_last_rd;
        w_mem_wr_req_nxt = r_mem_wr_req;
        w_mem_rd_req_nxt = r_mem_rd_req;
        w_len_nxt        = r_len;
        w_addr_nxt       = r_addr;
        w_owner_nxt      = r_owner;

        case (r_state)
            S_IDLE: begin
                if (w_pick_wr) begin
                    w_state_nxt      = S_WR;
                    w_last_rd_nxt    = 1'b0;
                    w_mem_wr_req_nxt = 1'b1;
                    w_len_nxt        = wr_burst_len;
                    w_addr_nxt       = wr_burst_addr;
                    w_owner_nxt      = 2'b01;
                end else if (rd_burst_req) begin
                    w_state_nxt      = S_RD;
                    w_last_rd_nxt    = 1'b1;
                    w_mem_rd_req_nxt = 1'b1;
                    w_len_nxt        = rd_burst_len;
                    w_addr_nxt       = rd_burst_addr;
                    w_owner_nxt      = 2'b10;
                end
            end
            S_WR: begin
                if (mem_wr_burst_finish) begin
                    w_state_nxt      = S_GAP;
                    w_mem_wr_req_nxt = 1'b0;
                    w_owner_nxt      = 2'b00;
                end
            end
            S_RD: begin
                if (mem_rd_burst_finish) begin
                    w_state_nxt      = S_GAP;
                    w_mem_rd_req_nxt = 1'b0;
                    w_owner_nxt      = 2'b00;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_wr_burst_req    = r_mem_wr_req;
    assign mem_rd_burst_req    = r_mem_rd_req;
    assign mem_burst_len       = r_len;
    assign mem_burst_addr      = r_addr;
    assign arb_owner           = r_owner;

    assign wr_burst_data_req   = w_wr_grant && mem_wr_burst_data_req;
    assign wr_burst_finish     = w_wr_grant && mem_wr_burst_finish;
    assign rd_burst_data_valid = w_rd_grant && mem_rd_burst_data_valid;
    assign rd_burst_finish     = w_rd_grant && mem_rd_burst_finish;

    assign mem_wr_burst_data   = wr_burst_data;
    assign rd_burst_data       = mem_rd_burst_data;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Self-checking bench for mem_burst_arbiter: directed scenarios plus a randomized
// run, all compared against an ownership-level reference model.
module tb_mem_burst_arbiter;

    localparam int DW = 32;
    localparam int AW = 28;
    localparam int LW = 10;
    localparam int VW = 110;

    logic          mem_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_burst_req = 1'b0;
    logic [LW-1:0] wr_burst_len = '0;
    logic [AW-1:0] wr_burst_addr = '0;
    logic [DW-1:0] wr_burst_data = '0;
    logic          wr_burst_data_req;
    logic          wr_burst_finish;
    logic          rd_burst_req = 1'b0;
    logic [LW-1:0] rd_burst_len = '0;
    logic [AW-1:0] rd_burst_addr = '0;
    logic          rd_burst_data_valid;
    logic [DW-1:0] rd_burst_data;
    logic          rd_burst_finish;
    logic          mem_wr_burst_req;
    logic          mem_rd_burst_req;
    logic [LW-1:0] mem_burst_len;
    logic [AW-1:0] mem_burst_addr;
    logic          mem_wr_burst_data_req = 1'b0;
    logic [DW-1:0] mem_wr_burst_data;
    logic          mem_rd_burst_data_valid = 1'b0;
    logic [DW-1:0] mem_rd_burst_data = '0;
    logic          mem_wr_burst_finish = 1'b0;
    logic          mem_rd_burst_finish = 1'b0;
    logic [1:0]    arb_owner;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 mem_clk = ~mem_clk;

    mem_burst_arbiter #(
        .MEM_DATA_BITS(DW),
        .ADDR_BITS    (AW),
        .BUSRT_BITS   (LW)
    ) dut (
        .mem_clk                (mem_clk),
        .rst_n                  (rst_n),
        .wr_burst_req           (wr_burst_req),
        .wr_burst_len           (wr_burst_len),
        .wr_burst_addr          (wr_burst_addr),
        .wr_burst_data          (wr_burst_data),
        .wr_burst_data_req      (wr_burst_data_req),
        .wr_burst_finish        (wr_burst_finish),
        .rd_burst_req           (rd_burst_req),
        .rd_burst_len           (rd_burst_len),
        .rd_burst_addr          (rd_burst_addr),
        .rd_burst_data_valid    (rd_burst_data_valid),
        .rd_burst_data          (rd_burst_data),
        .rd_burst_finish        (rd_burst_finish),
        .mem_wr_burst_req       (mem_wr_burst_req),
        .mem_rd_burst_req       (mem_rd_burst_req),
        .mem_burst_len          (mem_burst_len),
        .mem_burst_addr         (mem_burst_addr),
        .mem_wr_burst_data_req  (mem_wr_burst_data_req),
        .mem_wr_burst_data      (mem_wr_burst_data),
        .mem_rd_burst_data_valid(mem_rd_burst_data_valid),
        .mem_rd_burst_data      (mem_rd_burst_data),
        .mem_wr_burst_finish    (mem_wr_burst_finish),
        .mem_rd_burst_finish    (mem_rd_burst_finish),
        .arb_owner              (arb_owner)
    );

    // Reference model: who owns the port, whether a turnaround cycle is pending,
    // who had the last turn, and the command latched at grant time.
    int            m_owner;   // 0 none, 1 write, 2 read
    bit            m_gap;
    bit            m_last_rd;
    logic [LW-1:0] m_len;
    logic [AW-1:0] m_addr;

    always @(posedge mem_clk) begin
        if (!rst_n) begin
            m_owner   <= 0;
            m_gap     <= 1'b0;
            m_last_rd <= 1'b1;
            m_len     <= '0;
            m_addr    <= '0;
        end else if (m_owner == 0) begin
            if (m_gap) begin
                m_gap <= 1'b0;
            end else if (wr_burst_req && (!rd_burst_req || m_last_rd)) begin
                m_owner   <= 1;
                m_last_rd <= 1'b0;
                m_len     <= wr_burst_len;
                m_addr    <= wr_burst_addr;
            end else if (rd_burst_req) begin
                m_owner   <= 2;
                m_last_rd <= 1'b1;
                m_len     <= rd_burst_len;
                m_addr    <= rd_burst_addr;
            end
        end else if ((m_owner == 1 && mem_wr_burst_finish) || (m_owner == 2 && mem_rd_burst_finish)) begin
            m_owner <= 0;
            m_gap   <= 1'b1;
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        logic g_wr;
        logic g_rd;
        g_wr = (m_owner == 1) && rst_n;
        g_rd = (m_owner == 2) && rst_n;
        return {(m_owner == 1), (m_owner == 2), 2'(m_owner), m_len, m_addr,
                g_wr && mem_wr_burst_data_req, g_wr && mem_wr_burst_finish,
                g_rd && mem_rd_burst_data_valid, g_rd && mem_rd_burst_finish,
                mem_rd_burst_data, wr_burst_data};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {mem_wr_burst_req, mem_rd_burst_req, arb_owner, mem_burst_len, mem_burst_addr,
                wr_burst_data_req, wr_burst_finish, rd_burst_data_valid, rd_burst_finish,
                rd_burst_data, mem_wr_burst_data};
    endfunction

    task automatic tick();
        @(negedge mem_clk);
    endtask

    task automatic quiet_ctrl();
        mem_wr_burst_data_req   = 1'b0;
        mem_rd_burst_data_valid = 1'b0;
        mem_wr_burst_finish     = 1'b0;
        mem_rd_burst_finish     = 1'b0;
        mem_rd_burst_data       = DW'($urandom);
        wr_burst_data           = DW'($urandom);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        wr_burst_req  = 1'b1;
        rd_burst_req  = 1'b1;
        wr_burst_len  = LW'($urandom);
        wr_burst_addr = AW'($urandom);
        rd_burst_len  = LW'($urandom);
        rd_burst_addr = AW'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick(); quiet_ctrl(); #1;
            n_checks++;
            if ({mem_wr_burst_req, mem_rd_burst_req, arb_owner, mem_burst_len, mem_burst_addr} !== '0) begin
                n_fail++;
                $display("FAIL reset_state: got req=%b%b owner=%b len=%h addr=%h, expected all zero",
                         mem_wr_burst_req, mem_rd_burst_req, arb_owner, mem_burst_len, mem_burst_addr);
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_model: got %h expected %h", obs_vec(), exp_vec());
            end
        end
        tick(); quiet_ctrl();
        rst_n = 1'b1; wr_burst_req = 1'b0; rd_burst_req = 1'b0;
        #1;
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_tie();
        int waited;
        int kind;
        bit got;
        tick(); quiet_ctrl(); rst_n = 1'b0; #1;
        tick(); quiet_ctrl();
        rst_n = 1'b1; wr_burst_req = 1'b1; rd_burst_req = 1'b1;
        wr_burst_len = LW'($urandom); wr_burst_addr = AW'($urandom);
        rd_burst_len = LW'($urandom); rd_burst_addr = AW'($urandom);
        #1;
        for (int b = 0; b < 4; b++) begin
            got = 1'b0; waited = 0;
            for (int c = 0; c < 8 && !got; c++) begin
                tick(); quiet_ctrl(); #1;
                waited++;
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL tie_model: got %h expected %h", obs_vec(), exp_vec());
                end
                if (mem_wr_burst_req || mem_rd_burst_req) got = 1'b1;
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL tie_grant_timeout: burst %0d got no grant, expected one", b);
            end
            kind = mem_wr_burst_req ? 1 : 2;
            n_checks++;
            if (kind != ((b % 2 == 0) ? 1 : 2)) begin
                n_fail++;
                $display("FAIL tie_order: burst %0d granted %0d, expected %0d", b, kind, (b % 2 == 0) ? 1 : 2);
            end
            if (b > 0) begin
                n_checks++;
                if (waited != 3) begin
                    n_fail++;
                    $display("FAIL tie_spacing: finish-to-req %0d cycles, expected 3", waited);
                end
            end
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                tick(); quiet_ctrl();
                mem_wr_burst_data_req   = (kind == 1);
                mem_rd_burst_data_valid = (kind == 2);
                #1;
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL tie_beat: got %h expected %h", obs_vec(), exp_vec());
                end
            end
            tick(); quiet_ctrl();
            mem_wr_burst_finish = (kind == 1);
            mem_rd_burst_finish = (kind == 2);
            #1;
            n_checks++;
            if ({wr_burst_finish, rd_burst_finish} !== ((kind == 1) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL tie_finish: got wr/rd finish %b%b, expected %s side only",
                         wr_burst_finish, rd_burst_finish, (kind == 1) ? "write" : "read");
            end
        end
        tick(); quiet_ctrl();
        wr_burst_req = 1'b0; rd_burst_req = 1'b0;
        #1;
    endtask

    task automatic test_single_write();
        int routed;
        tick(); quiet_ctrl();
        wr_burst_req = 1'b1; wr_burst_len = LW'(128); wr_burst_addr = AW'(32'h1000);
        #1;
        tick(); quiet_ctrl(); #1;
        n_checks++;
        if ({mem_wr_burst_req, mem_rd_burst_req, arb_owner, mem_burst_len, mem_burst_addr} !==
            {1'b1, 1'b0, 2'b01, LW'(128), AW'(32'h1000)}) begin
            n_fail++;
            $display("FAIL write_grant: got req=%b%b owner=%b len=%0d addr=%h, expected 10/01/128/1000",
                     mem_wr_burst_req, mem_rd_burst_req, arb_owner, mem_burst_len, mem_burst_addr);
        end
        routed = 0;
        for (int i = 0; i < 128; i++) begin
            tick(); quiet_ctrl();
            mem_wr_burst_data_req = 1'b1;
            if (i == 64) begin
                wr_burst_addr = AW'(32'h2000);
                wr_burst_len  = LW'(5);
            end
            #1;
            if (wr_burst_data_req) routed++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL write_beat: beat %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (routed != 128) begin
            n_fail++;
            $display("FAIL write_routed: got %0d data requests, expected 128", routed);
        end
        tick(); quiet_ctrl();
        mem_wr_burst_finish = 1'b1;
        #1;
        n_checks++;
        if ({wr_burst_finish, mem_burst_addr, mem_burst_len} !== {1'b1, AW'(32'h1000), LW'(128)}) begin
            n_fail++;
            $display("FAIL write_latch_finish: got fin=%b addr=%h len=%0d, expected 1/1000/128",
                     wr_burst_finish, mem_burst_addr, mem_burst_len);
        end
        tick(); quiet_ctrl();
        wr_burst_req = 1'b0;
        #1;
        n_checks++;
        if ({wr_burst_finish, mem_wr_burst_req, arb_owner} !== 4'b0000) begin
            n_fail++;
            $display("FAIL write_release: got fin=%b req=%b owner=%b, expected all 0",
                     wr_burst_finish, mem_wr_burst_req, arb_owner);
        end
        tick(); quiet_ctrl(); #1;
    endtask

    task automatic test_isolation();
        bit got;
        tick(); quiet_ctrl();
        rd_burst_req = 1'b1; rd_burst_len = LW'($urandom); rd_burst_addr = AW'($urandom);
        #1;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            tick(); quiet_ctrl(); #1;
            if (mem_rd_burst_req) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL iso_grant_timeout: got no read grant, expected one");
        end
        for (int i = 0; i < 20; i++) begin
            tick(); quiet_ctrl();
            mem_wr_burst_data_req   = 1'($urandom);
            mem_wr_burst_finish     = 1'($urandom);
            mem_rd_burst_data_valid = 1'($urandom);
            if (i == 10) rd_burst_req = 1'b0;
            #1;
            n_checks++;
            if ({wr_burst_data_req, wr_burst_finish, rd_burst_data_valid, mem_rd_burst_req} !==
                {2'b00, mem_rd_burst_data_valid, 1'b1}) begin
                n_fail++;
                $display("FAIL iso_gate: got wdr=%b wfin=%b rdv=%b rreq=%b, expected 0/0/%b/1",
                         wr_burst_data_req, wr_burst_finish, rd_burst_data_valid, mem_rd_burst_req,
                         mem_rd_burst_data_valid);
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL iso_model: got %h expected %h", obs_vec(), exp_vec());
            end
        end
        tick(); quiet_ctrl();
        mem_rd_burst_finish = 1'b1;
        #1;
        n_checks++;
        if (rd_burst_finish !== 1'b1) begin
            n_fail++;
            $display("FAIL iso_finish: got rd_burst_finish=%b, expected 1", rd_burst_finish);
        end
        tick(); quiet_ctrl(); #1;
    endtask

    task automatic test_reset_mid_burst();
        bit got;
        tick(); quiet_ctrl();
        wr_burst_req = 1'b1; wr_burst_len = LW'($urandom); wr_burst_addr = AW'($urandom);
        #1;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            tick(); quiet_ctrl(); #1;
            if (mem_wr_burst_req) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL rmid_grant_timeout: got no write grant, expected one");
        end
        tick(); quiet_ctrl(); mem_wr_burst_data_req = 1'b1; #1;
        tick(); quiet_ctrl();
        rst_n = 1'b0; mem_wr_burst_data_req = 1'b1;
        #1;
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL rmid_during: got %h expected %h", obs_vec(), exp_vec());
        end
        tick(); quiet_ctrl();
        rst_n = 1'b1; wr_burst_req = 1'b0; mem_wr_burst_finish = 1'b1;
        #1;
        n_checks++;
        if ({wr_burst_finish, mem_wr_burst_req, arb_owner, mem_burst_len} !== '0) begin
            n_fail++;
            $display("FAIL rmid_drop: got fin=%b req=%b owner=%b len=%h, expected all 0",
                     wr_burst_finish, mem_wr_burst_req, arb_owner, mem_burst_len);
        end
        tick(); quiet_ctrl();
        rd_burst_req = 1'b1; rd_burst_len = LW'($urandom); rd_burst_addr = AW'($urandom);
        #1;
        tick(); quiet_ctrl(); #1;
        n_checks++;
        if (mem_rd_burst_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_idle: got mem_rd_burst_req=%b one cycle after request, expected 1", mem_rd_burst_req);
        end
        tick(); quiet_ctrl(); mem_rd_burst_finish = 1'b1; #1;
        tick(); quiet_ctrl(); rd_burst_req = 1'b0; #1;
    endtask

    task automatic test_random();
        int left;
        bit wr_drop;
        bit rd_drop;
        left = 0; wr_drop = 1'b0; rd_drop = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick(); quiet_ctrl();
            if (wr_drop) begin
                wr_burst_req = 1'b0; wr_drop = 1'b0;
            end else if (!wr_burst_req && $urandom_range(0, 3) == 0) begin
                wr_burst_req  = 1'b1;
                wr_burst_len  = ($urandom_range(0, 5) == 0) ? '0 : LW'($urandom);
                wr_burst_addr = AW'($urandom);
            end else if ($urandom_range(0, 5) == 0) begin
                wr_burst_len  = LW'($urandom);
                wr_burst_addr = AW'($urandom);
            end
            if (rd_drop) begin
                rd_burst_req = 1'b0; rd_drop = 1'b0;
            end else if (!rd_burst_req && $urandom_range(0, 3) == 0) begin
                rd_burst_req  = 1'b1;
                rd_burst_len  = ($urandom_range(0, 5) == 0) ? '0 : LW'($urandom);
                rd_burst_addr = AW'($urandom);
            end else if ($urandom_range(0, 5) == 0) begin
                rd_burst_len  = LW'($urandom);
                rd_burst_addr = AW'($urandom);
            end
            if (mem_wr_burst_req || mem_rd_burst_req) begin
                if (left == 0) left = $urandom_range(1, 6);
                if (left == 1) begin
                    if (mem_wr_burst_req) begin
                        mem_wr_burst_finish = 1'b1; wr_drop = 1'b1;
                    end else begin
                        mem_rd_burst_finish = 1'b1; rd_drop = 1'b1;
                    end
                end else begin
                    mem_wr_burst_data_req   = mem_wr_burst_req && 1'($urandom);
                    mem_rd_burst_data_valid = mem_rd_burst_req && 1'($urandom);
                end
                left--;
            end
            if (!mem_wr_burst_req) begin
                mem_wr_burst_data_req = 1'($urandom);
                mem_wr_burst_finish   = ($urandom_range(0, 7) == 0);
            end
            if (!mem_rd_burst_req) begin
                mem_rd_burst_data_valid = 1'($urandom);
                mem_rd_burst_finish     = ($urandom_range(0, 7) == 0);
            end
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model: cycle %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
            n_checks++;
            if (mem_wr_burst_req && mem_rd_burst_req) begin
                n_fail++;
                $display("FAIL random_exclusive: cycle %0d got both mem requests 1, expected at most one", i);
            end
        end
        tick(); quiet_ctrl();
        wr_burst_req = 1'b0; rd_burst_req = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_write();
        test_isolation();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
